// File: rtl/alu_arb_pkg.sv
// Shared types and constants for the ALU request arbiter.
package alu_arb_pkg;

  localparam int CMD_W = 7;

  typedef struct packed {
    logic       a_en;
    logic       b_en;
    logic [2:0] a_op;
    logic [1:0] b_op;
  } alu_cmd_t;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } arb_state_t;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first asserted request at or after the pointer.
module rr_picker #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [ID_W-1:0]    ptr_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [ID_W-1:0]    id_o,
  output logic               any_o
);

  always_comb begin
    logic            found;
    logic [ID_W-1:0] idx;
    found   = 1'b0;
    idx     = '0;
    grant_o = '0;
    id_o    = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx = ID_W'((32'(ptr_i) + i) % NUM_REQ);
      if (!found && req_i[idx]) begin
        found        = 1'b1;
        grant_o[idx] = 1'b1;
        id_o         = idx;
      end
    end
    any_o = found;
  end

endmodule

// File: rtl/alu_req_arbiter.sv
// Round-robin sharing of one ALU among NUM_REQ requesters.
// Optional per-requester grant counters when ALU_ARB_STATS_EN is defined.
module alu_req_arbiter
  import alu_arb_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  parameter  int DATA_W  = 8,
  parameter  int ALU_LAT = 1,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*CMD_W-1:0]  req_cmd,
  input  logic [NUM_REQ*DATA_W-1:0] req_a,
  input  logic [NUM_REQ*DATA_W-1:0] req_b,
  output logic                      resp_valid,
  input  logic                      resp_ready,
  output logic [ID_W-1:0]           resp_id,
  output logic [DATA_W:0]           resp_c,
  output logic                      a_en,
  output logic                      b_en,
  output logic [2:0]                a_op,
  output logic [1:0]                b_op,
  output logic                      ALU_en,
  output logic [DATA_W-1:0]         A,
  output logic [DATA_W-1:0]         B,
  input  logic [DATA_W:0]           C,
  output logic                      busy
`ifdef ALU_ARB_STATS_EN
  ,
  output logic [NUM_REQ*16-1:0]     grant_cnt
`endif
);

  arb_state_t          state_q;
  logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
  alu_cmd_t            cmd_q;
  logic [DATA_W-1:0]   a_q, b_q;
  logic [ID_W-1:0]     id_q;
  logic [DATA_W:0]     c_q;
  logic [1:0]          wait_cnt_q;

  logic [NUM_REQ-1:0]  pick_grant;
  logic [ID_W-1:0]     pick_id;
  logic                pick_any;
  logic                hs;

  rr_picker #(
    .NUM_REQ(NUM_REQ),
    .ID_W   (ID_W)
  ) u_picker (
    .req_i  (req_valid),
    .ptr_i  (rr_ptr_q),
    .grant_o(pick_grant),
    .id_o   (pick_id),
    .any_o  (pick_any)
  );

  // Grant is only offered in IDLE, so any offered grant is also a handshake.
  assign req_ready = (!rst && state_q == IDLE) ? pick_grant : '0;
  assign hs        = !rst && state_q == IDLE && pick_any;
  assign rr_ptr_d  = (pick_id == ID_W'(NUM_REQ - 1)) ? '0 : pick_id + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      cmd_q      <= '0;
      a_q        <= '0;
      b_q        <= '0;
      id_q       <= '0;
      c_q        <= '0;
      wait_cnt_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (hs) begin
            cmd_q    <= alu_cmd_t'(req_cmd[int'(pick_id)*CMD_W +: CMD_W]);
            a_q      <= req_a[int'(pick_id)*DATA_W +: DATA_W];
            b_q      <= req_b[int'(pick_id)*DATA_W +: DATA_W];
            id_q     <= pick_id;
            rr_ptr_q <= rr_ptr_d;
            state_q  <= ISSUE;
          end
        end
        ISSUE: begin
          wait_cnt_q <= 2'(ALU_LAT - 1);
          state_q    <= WAIT;
        end
        WAIT: begin
          if (wait_cnt_q == '0) begin
            c_q     <= C;
            state_q <= RESP;
          end else begin
            wait_cnt_q <= wait_cnt_q - 1'b1;
          end
        end
        RESP: begin
          if (resp_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ALU_en     = (state_q == ISSUE);
  assign resp_valid = (state_q == RESP);
  assign busy       = (state_q != IDLE);
  assign a_en       = cmd_q.a_en;
  assign b_en       = cmd_q.b_en;
  assign a_op       = cmd_q.a_op;
  assign b_op       = cmd_q.b_op;
  assign A          = a_q;
  assign B          = b_q;
  assign resp_id    = id_q;
  assign resp_c     = c_q;

`ifdef ALU_ARB_STATS_EN
  logic [15:0] cnt_q [NUM_REQ];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) cnt_q[i] <= '0;
    end else if (hs && cnt_q[pick_id] != '1) begin
      cnt_q[pick_id] <= cnt_q[pick_id] + 16'd1;
    end
  end

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_cnt
    assign grant_cnt[g*16 +: 16] = cnt_q[g];
  end
`endif

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Self-checking bench for alu_req_arbiter: directed vectors, corner sequences, random traffic.
module tb_alu_req_arbiter;
  import alu_arb_pkg::*;

  localparam int NUM_REQ = 4;
  localparam int DATA_W  = 8;
  localparam int ALU_LAT = 1;
  localparam int ID_W    = $clog2(NUM_REQ);
  localparam int CMDV_W  = NUM_REQ * CMD_W;
  localparam int OPV_W   = NUM_REQ * DATA_W;
  localparam int RESP_AT = ALU_LAT + 2;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NUM_REQ-1:0]   req_valid, req_ready;
  logic [CMDV_W-1:0]    req_cmd;
  logic [OPV_W-1:0]     req_a, req_b;
  logic                 resp_valid, resp_ready;
  logic [ID_W-1:0]      resp_id;
  logic [DATA_W:0]      resp_c, C;
  logic                 a_en, b_en, ALU_en, busy;
  logic [2:0]           a_op;
  logic [1:0]           b_op;
  logic [DATA_W-1:0]    A, B;
`ifdef ALU_ARB_STATS_EN
  logic [NUM_REQ*16-1:0] grant_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_req_arbiter #(
    .NUM_REQ(NUM_REQ),
    .DATA_W (DATA_W),
    .ALU_LAT(ALU_LAT)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_cmd(req_cmd),
    .req_a(req_a), .req_b(req_b),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id), .resp_c(resp_c),
    .a_en(a_en), .b_en(b_en), .a_op(a_op), .b_op(b_op), .ALU_en(ALU_en),
    .A(A), .B(B), .C(C), .busy(busy)
`ifdef ALU_ARB_STATS_EN
    , .grant_cnt(grant_cnt)
`endif
  );

  function automatic logic [DATA_W:0] alu_fn(alu_cmd_t c, logic [DATA_W-1:0] a, logic [DATA_W-1:0] b);
    logic [DATA_W:0] av, bv;
    av = c.a_en ? {1'b0, a} : '0;
    bv = c.b_en ? {1'b0, b} : '0;
    case (c.a_op)
      3'd0:    return av + bv;
      3'd1:    return av - bv;
      default: return av ^ bv;
    endcase
  endfunction

  // ALU stand-in: result valid one cycle after ALU_en, garbage otherwise.
  always @(posedge clk) begin
    if (ALU_en) C <= alu_fn(alu_cmd_t'({a_en, b_en, a_op, b_op}), A, B);
    else        C <= 9'h155;
  end

  // Reference model: transaction-level view counting cycles since grant.
  int          m_rr = 0;
  bit          m_busy = 0;
  int          m_cnt = 0;
  int          m_id = 0;
  alu_cmd_t    m_cmd;
  logic [DATA_W-1:0] m_a, m_b;
  logic [DATA_W:0]   m_c;
  int          m_stats [NUM_REQ];
  int          dut_grants [$];

  function automatic int pick(logic [NUM_REQ-1:0] v, int ptr);
    for (int i = 0; i < NUM_REQ; i++)
      if (v[(ptr + i) % NUM_REQ]) return (ptr + i) % NUM_REQ;
    return -1;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_check();
    int g;
    logic [NUM_REQ-1:0] exp_rdy;
    bit rv;
    g = pick(req_valid, m_rr);
    exp_rdy = '0;
    if (!m_busy && g >= 0) exp_rdy[g] = 1'b1;
    chk("req_ready", 32'(req_ready), 32'(exp_rdy));
    chk("busy", 32'(busy), 32'(m_busy));
    chk("ALU_en", 32'(ALU_en), 32'(m_busy && m_cnt == 1));
    rv = m_busy && m_cnt >= RESP_AT;
    chk("resp_valid", 32'(resp_valid), 32'(rv));
    if (rv) begin
      chk("resp_id", 32'(resp_id), 32'(m_id));
      chk("resp_c", 32'(resp_c), 32'(m_c));
    end
    if (m_busy && m_cnt < RESP_AT)
      chk("alu_pins", 32'({a_en, b_en, a_op, b_op, A, B}), 32'({m_cmd, m_a, m_b}));
`ifdef ALU_ARB_STATS_EN
    for (int i = 0; i < NUM_REQ; i++)
      chk("grant_cnt", 32'(grant_cnt[i*16 +: 16]), 32'(m_stats[i]));
`endif
  endtask

  task automatic model_update();
    int g;
    if (rst) begin
      m_busy = 0;
      m_rr   = 0;
      for (int i = 0; i < NUM_REQ; i++) m_stats[i] = 0;
      return;
    end
    if (!m_busy) begin
      g = pick(req_valid, m_rr);
      if (g >= 0) begin
        m_cmd  = alu_cmd_t'(req_cmd[g*CMD_W +: CMD_W]);
        m_a    = req_a[g*DATA_W +: DATA_W];
        m_b    = req_b[g*DATA_W +: DATA_W];
        m_c    = alu_fn(m_cmd, m_a, m_b);
        m_id   = g;
        m_busy = 1;
        m_cnt  = 1;
        m_rr   = (g + 1) % NUM_REQ;
        if (m_stats[g] < 65535) m_stats[g]++;
      end
    end else if (m_cnt >= RESP_AT) begin
      if (resp_ready) m_busy = 0;
    end else begin
      m_cnt++;
    end
  endtask

  // One clock: settle, check against model, advance model on the edge.
  task automatic tick();
    #1;
    if (!rst) begin
      for (int i = 0; i < NUM_REQ; i++)
        if (req_valid[i] && req_ready[i]) dut_grants.push_back(i);
      model_check();
    end
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (m_busy && n < 30) begin tick(); n++; end
    checks++;
    if (m_busy) begin
      errors++;
      $display("FAIL drain_timeout: got busy expected idle");
    end
  endtask

  task automatic set_req(int idx, alu_cmd_t cmd, logic [DATA_W-1:0] a, logic [DATA_W-1:0] b);
    req_cmd[idx*CMD_W +: CMD_W]   = cmd;
    req_a[idx*DATA_W +: DATA_W]   = a;
    req_b[idx*DATA_W +: DATA_W]   = b;
  endtask

  task automatic run_single(int idx, alu_cmd_t cmd, logic [DATA_W-1:0] a, logic [DATA_W-1:0] b);
    set_req(idx, cmd, a, b);
    req_valid = NUM_REQ'(1 << idx);
    tick();
    req_valid  = '0;
    resp_ready = 1'b1;
    drain();
  endtask

  task automatic check_zero(string name);
    chk(name, 32'({req_ready, resp_valid, resp_id, resp_c, ALU_en, a_en, b_en, a_op, b_op, busy}), 32'd0);
    chk(name, 32'({A, B}), 32'd0);
  endtask

  task automatic collect(int want, string name);
    int n;
    n = 0;
    dut_grants.delete();
    while (dut_grants.size() < want && n < 80) begin tick(); n++; end
    chk({name, "_count"}, 32'(dut_grants.size()), 32'(want));
  endtask

  typedef struct {
    int              idx;
    alu_cmd_t        cmd;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [DATA_W:0]   exp_c;
  } vec_t;

  vec_t tbl [5];
  int   rr_exp [5];
  int   lat;

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{0, '{1'b1, 1'b1, 3'd0, 2'd0}, 8'd5,   8'd3,   9'd8};
    tbl[1] = '{1, '{1'b1, 1'b1, 3'd1, 2'd1}, 8'd10,  8'd3,   9'd7};
    tbl[2] = '{2, '{1'b1, 1'b1, 3'd2, 2'd2}, 8'hF0,  8'h0F,  9'h0FF};
    tbl[3] = '{3, '{1'b1, 1'b1, 3'd0, 2'd3}, 8'hFF,  8'hFF,  9'h1FE};
    tbl[4] = '{1, '{1'b1, 1'b0, 3'd0, 2'd0}, 8'd7,   8'd100, 9'd7};
    rr_exp = '{0, 1, 2, 3, 0};

    rst = 1'b1; req_valid = '1; resp_ready = 1'b0;
    req_cmd = '0; req_a = '0; req_b = '0;
    @(negedge clk);
    repeat (3) begin tick(); #1; check_zero("reset_outputs"); end
    rst = 1'b0; req_valid = '0; resp_ready = 1'b1;
    tick();

    // Directed single operations with latency check.
    for (int v = 0; v < 5; v++) begin
      set_req(tbl[v].idx, tbl[v].cmd, tbl[v].a, tbl[v].b);
      req_valid = NUM_REQ'(1 << tbl[v].idx);
      #1;
      chk("tbl_grant", 32'(req_ready), 32'(1 << tbl[v].idx));
      tick();
      req_valid = '0;
      lat = 1;
      while (lat < 20) begin #1; if (resp_valid) break; tick(); lat++; end
      chk("tbl_latency", 32'(lat), 32'(RESP_AT));
      chk("tbl_resp_id", 32'(resp_id), 32'(tbl[v].idx));
      chk("tbl_resp_c", 32'(resp_c), 32'(tbl[v].exp_c));
      tick();
      drain();
    end

    // Reset while the op waits on the ALU: op dropped, pointer back to 0.
    set_req(2, '{1'b1, 1'b1, 3'd0, 2'd0}, 8'd1, 8'd2);
    req_valid = 4'b0100;
    tick();
    req_valid = '0;
    tick();
    rst = 1'b1; req_valid = '1;
    repeat (3) begin tick(); #1; check_zero("midwait_reset"); end
    rst = 1'b0;
    #1;
    chk("post_reset_grant0", 32'(req_ready), 32'b0001);
    chk("post_reset_no_resp", 32'(resp_valid), 32'd0);

    // Round-robin with all requesting.
    resp_ready = 1'b1;
    collect(5, "rr");
    for (int k = 0; k < 5 && k < dut_grants.size(); k++)
      chk("rr_order", 32'(dut_grants[k]), 32'(rr_exp[k]));
    req_valid = '0;
    drain();

    // Pointer at 3 with requests 0 and 2: wrap to 0 then skip to 2.
    run_single(2, '{1'b1, 1'b1, 3'd0, 2'd0}, 8'd9, 8'd9);
    req_valid = 4'b0101;
    collect(2, "wrap");
    if (dut_grants.size() == 2) begin
      chk("wrap_first", 32'(dut_grants[0]), 32'd0);
      chk("wrap_second", 32'(dut_grants[1]), 32'd2);
    end
    req_valid = '0;
    drain();

    // Backpressure: response held, no grants, next grant right after handshake.
    set_req(1, '{1'b1, 1'b1, 3'd0, 2'd0}, 8'd20, 8'd22);
    resp_ready = 1'b0;
    req_valid = 4'b0010;
    tick();
    req_valid = '1;
    lat = 1;
    while (lat < 20) begin #1; if (resp_valid) break; tick(); lat++; end
    chk("bp_latency", 32'(lat), 32'(RESP_AT));
    for (int k = 0; k < 5; k++) begin
      chk("bp_valid", 32'(resp_valid), 32'd1);
      chk("bp_c", 32'(resp_c), 32'd42);
      chk("bp_id", 32'(resp_id), 32'd1);
      chk("bp_no_grant", 32'(req_ready), 32'd0);
      tick();
      #1;
    end
    resp_ready = 1'b1;
    tick();
    #1;
    chk("bp_released", 32'(resp_valid), 32'd0);
    chk("bp_next_grant", 32'(req_ready), 32'b0100);
    req_valid = '0;
    tick();
    drain();

`ifdef ALU_ARB_STATS_EN
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    repeat (3) run_single(1, '{1'b1, 1'b1, 3'd0, 2'd0}, 8'd1, 8'd1);
    #1;
    chk("stats_req0", 32'(grant_cnt[0 +: 16]), 32'd0);
    chk("stats_req1", 32'(grant_cnt[16 +: 16]), 32'd3);
    chk("stats_req2", 32'(grant_cnt[32 +: 16]), 32'd0);
    chk("stats_req3", 32'(grant_cnt[48 +: 16]), 32'd0);
`endif

    // Random traffic against the model.
    for (int c = 0; c < 400; c++) begin
      req_valid  = NUM_REQ'($urandom);
      req_cmd    = CMDV_W'($urandom);
      req_a      = OPV_W'($urandom);
      req_b      = OPV_W'($urandom);
      resp_ready = ($urandom_range(0, 3) != 0);
      rst        = ($urandom_range(0, 99) == 0);
      tick();
    end
    rst = 1'b0; req_valid = '0; resp_ready = 1'b1;
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
